// File: rtl/data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl
//
// Data RAM for the memory module, sitting between the control unit and the
// register file. It replaces the old single-cycle RAM with a request/busy
// handshake, a configurable read latency and three addressing modes
// (direct, indirect through a pointer word, indexed base+offset). A sweep
// state machine zeroes every word after reset and whenever clrMem is seen.
//
// Parameters
//   width        data word width in bits
//   length       address width; the array holds 2**length words
//   readLatency  cycles from read accept to dataReady (must be >= 1)
//
// Ports
//   clk          clock, rising edge
//   clr          asynchronous active-high reset
//   req          request strobe, only looked at while busy is low
//   writeEnable  1 = write, 0 = read (qualified by req)
//   mode         00 direct, 01 indirect, 10 indexed, 11 reserved
//   addr         base address
//   offset       index offset, indexed mode only
//   writeData    data to write
//   clrMem       request to zero the whole array
//   busy         high while no request can be accepted
//   dataReady    one-cycle pulse, readData valid in that cycle
//   readData     last read result, held between reads
//   error        one-cycle pulse on a reserved-mode request
//
// Indirect mode takes its pointer from the low length bits of a stored word,
// so width is expected to be at least length.
// ---------------------------------------------------------------------------
module data_ram_ctrl #(
  parameter int width       = 8,
  parameter int length      = 8,
  parameter int readLatency = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              writeEnable,
  input  logic [1:0]        mode,
  input  logic [length-1:0] addr,
  input  logic [length-1:0] offset,
  input  logic [width-1:0]  writeData,
  input  logic              clrMem,
  output logic              busy,
  output logic              dataReady,
  output logic [width-1:0]  readData,
  output logic              error
);

  localparam int DEPTH = 2 ** length;

  // The latency counter only ever holds readLatency-1 down to 0.
  localparam int LAT_W = (readLatency > 1) ? $clog2(readLatency) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(readLatency - 1);

  localparam logic [1:0] MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MODE_INDIRECT = 2'b01;
  localparam logic [1:0] MODE_INDEXED  = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01,
    PTR   = 2'b10,
    WAIT  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [length-1:0]  clear_cnt_q, clear_cnt_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [length-1:0]  rd_addr_q, rd_addr_d;
  logic [width-1:0]   read_data_q, read_data_d;
  logic               data_ready_q, data_ready_d;
  logic               error_q, error_d;

  // Storage; deliberately has no reset, it is only zeroed by the sweep.
  logic [width-1:0]   mem [DEPTH];

  // Single write port shared by the sweep and by accepted writes.
  logic               mem_we;
  logic [length-1:0]  mem_waddr;
  logic [width-1:0]   mem_wdata;

  // Address candidates derived from the request inputs.
  logic [length-1:0]  indexed_addr;
  logic [length-1:0]  ptr_addr;
  logic [length-1:0]  rd_accept_addr;
  logic [length-1:0]  wr_accept_addr;

  // Indexed addresses wrap: the carry out of addr+offset is dropped by the
  // length-bit result. The indirect pointer keeps only its low length bits.
  // A read only latches addr in indirect mode; the pointer is fetched in PTR
  // so the pointer word is read one cycle later. A write dereferences the
  // pointer immediately, using whatever the pointer word holds right now.
  always_comb begin
    indexed_addr = addr + offset;
    ptr_addr     = mem[addr][length-1:0];

    rd_accept_addr = addr;
    wr_accept_addr = addr;
    case (mode)
      MODE_DIRECT: begin
        rd_accept_addr = addr;
        wr_accept_addr = addr;
      end
      MODE_INDIRECT: begin
        rd_accept_addr = addr;
        wr_accept_addr = ptr_addr;
      end
      MODE_INDEXED: begin
        rd_accept_addr = indexed_addr;
        wr_accept_addr = indexed_addr;
      end
      default: begin
        rd_accept_addr = addr;
        wr_accept_addr = addr;
      end
    endcase
  end

  // Next-state and datapath control. dataReady and error are pulses, so
  // they default to 0 and are raised only on the cycle that earns them.
  // readData defaults to holding its value; only a read completion loads it.
  always_comb begin
    state_d      = state_q;
    clear_cnt_d  = clear_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    rd_addr_d    = rd_addr_q;
    read_data_d  = read_data_q;
    data_ready_d = 1'b0;
    error_d      = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = clear_cnt_q;
    mem_wdata    = '0;

    case (state_q)
      // One word zeroed per cycle; req and clrMem are not looked at here.
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_cnt_q;
        mem_wdata   = '0;
        clear_cnt_d = clear_cnt_q + length'(1);
        if (&clear_cnt_q) begin
          state_d = IDLE;
        end
      end

      // clrMem beats req so a clear request never loses to a pending access.
      IDLE: begin
        if (clrMem) begin
          state_d     = CLEAR;
          clear_cnt_d = '0;
        end else if (req) begin
          if (mode == MODE_RSVD) begin
            error_d = 1'b1;
          end else if (writeEnable) begin
            mem_we    = 1'b1;
            mem_waddr = wr_accept_addr;
            mem_wdata = writeData;
          end else begin
            rd_addr_d = rd_accept_addr;
            lat_cnt_d = LAT_LOAD;
            state_d   = (mode == MODE_INDIRECT) ? PTR : WAIT;
          end
        end
      end

      // Replace the latched pointer location with the address it holds.
      PTR: begin
        rd_addr_d = mem[rd_addr_q][length-1:0];
        state_d   = WAIT;
      end

      // Burn the remaining latency, then return the word. Going back to IDLE
      // on this edge drops busy in the same cycle dataReady is high.
      WAIT: begin
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end else begin
          read_data_d  = mem[rd_addr_q];
          data_ready_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d     = CLEAR;
        clear_cnt_d = '0;
      end
    endcase
  end

  // Control registers. Reset forces a fresh sweep from address 0 and throws
  // away any read in flight, so no dataReady follows a reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= CLEAR;
      clear_cnt_q  <= '0;
      lat_cnt_q    <= '0;
      rd_addr_q    <= '0;
      read_data_q  <= '0;
      data_ready_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_cnt_q  <= clear_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      rd_addr_q    <= rd_addr_d;
      read_data_q  <= read_data_d;
      data_ready_q <= data_ready_d;
      error_q      <= error_d;
    end
  end

  // Array write port; kept free of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy      = (state_q != IDLE);
  assign dataReady = data_ready_q;
  assign readData  = read_data_q;
  assign error     = error_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_ram_ctrl
//
// Directed bench for data_ram_ctrl with width=8, length=4, readLatency=2.
// Every read pushes its expected word and the cycle its dataReady is due
// onto a scoreboard; a monitor pops and compares whenever dataReady is seen.
// ---------------------------------------------------------------------------
module tb_data_ram_ctrl;

  localparam int W   = 8;
  localparam int L   = 4;
  localparam int LAT = 2;

  localparam logic [1:0] DIRECT   = 2'b00;
  localparam logic [1:0] INDIRECT = 2'b01;
  localparam logic [1:0] INDEXED  = 2'b10;
  localparam logic [1:0] RSVD     = 2'b11;

  logic         clk;
  logic         clr;
  logic         req;
  logic         writeEnable;
  logic [1:0]   mode;
  logic [L-1:0] addr;
  logic [L-1:0] offset;
  logic [W-1:0] writeData;
  logic         clrMem;
  logic         busy;
  logic         dataReady;
  logic [W-1:0] readData;
  logic         error;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } expRead_t;

  expRead_t sbQueue[$];
  int       tests    = 0;
  int       failures = 0;
  int       cyc      = 0;

  data_ram_ctrl #(
    .width       (W),
    .length      (L),
    .readLatency (LAT)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .req         (req),
    .writeEnable (writeEnable),
    .mode        (mode),
    .addr        (addr),
    .offset      (offset),
    .writeData   (writeData),
    .clrMem      (clrMem),
    .busy        (busy),
    .dataReady   (dataReady),
    .readData    (readData),
    .error       (error)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [1:0] m,
                               input logic [L-1:0] a, input logic [L-1:0] o,
                               input logic [W-1:0] d, input logic cm);
    req         = r;
    writeEnable = we;
    mode        = m;
    addr        = a;
    offset      = o;
    writeData   = d;
    clrMem      = cm;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, DIRECT, '0, '0, '0, 1'b0);
  endtask

  task automatic doWrite(input logic [1:0] m, input logic [L-1:0] a,
                         input logic [L-1:0] o, input logic [W-1:0] d);
    applyStimulus(1'b1, 1'b1, m, a, o, d, 1'b0);
    tick(1);
    idleInputs();
  endtask

  // Called one step after an edge: the accept edge is the next one, and
  // dataReady must be high LAT edges later (one more for indirect).
  task automatic pushRead(input logic [1:0] m, input logic [W-1:0] expData);
    expRead_t e;
    e.data = expData;
    e.due  = cyc + 1 + LAT + ((m == INDIRECT) ? 1 : 0);
    sbQueue.push_back(e);
  endtask

  task automatic doRead(input logic [1:0] m, input logic [L-1:0] a,
                        input logic [L-1:0] o, input logic [W-1:0] expData);
    pushRead(m, expData);
    applyStimulus(1'b1, 1'b0, m, a, o, '0, 1'b0);
    tick(1);
    idleInputs();
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while ((sbQueue.size() != 0 || busy) && n < 40) begin
      tick(1);
      n++;
    end
    checkOutput({tag, " pending reads"}, sbQueue.size(), 0);
    checkOutput({tag, " busy"}, {31'd0, busy}, 0);
    sbQueue.delete();
  endtask

  // After clr falls or clrMem is taken: 16 cycles busy, then idle.
  task automatic checkSweep(input string tag, input logic [W-1:0] heldData);
    for (int k = 0; k < (1 << L); k++) begin
      checkOutput({tag, " busy"}, {31'd0, busy}, 1);
      checkOutput({tag, " readData held"}, {24'd0, readData}, {24'd0, heldData});
      tick(1);
    end
    checkOutput({tag, " idle"}, {31'd0, busy}, 0);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin : monitor
    expRead_t e;
    if (dataReady === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected dataReady", {31'd0, dataReady}, 0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput("read data", {24'd0, readData}, {24'd0, e.data});
        checkOutput("read latency cycle", cyc, e.due);
      end
    end
  end

  initial begin
    clr = 1'b0;
    idleInputs();
    #1 clr = 1'b1;
    tick(2);

    // Reset values
    checkOutput("reset busy", {31'd0, busy}, 1);
    checkOutput("reset dataReady", {31'd0, dataReady}, 0);
    checkOutput("reset readData", {24'd0, readData}, 0);
    checkOutput("reset error", {31'd0, error}, 0);

    // Power-up sweep, then every word reads back as zero
    clr = 1'b0;
    checkSweep("initial sweep", 8'h00);
    for (int a = 0; a < (1 << L); a++) begin
      doRead(DIRECT, L'(a), '0, 8'h00);
      waitDone("zero read");
    end

    // Direct write/read and hold afterwards
    doWrite(DIRECT, 4'd3, '0, 8'hA5);
    doRead(DIRECT, 4'd3, '0, 8'hA5);
    waitDone("direct read");
    tick(3);
    checkOutput("readData held", {24'd0, readData}, 32'h0000_00A5);
    checkOutput("dataReady low after pulse", {31'd0, dataReady}, 0);

    // Indirect reads, upper pointer bits ignored, indirect write
    doWrite(DIRECT, 4'd2, '0, 8'h07);
    doWrite(DIRECT, 4'd7, '0, 8'h3C);
    doRead(INDIRECT, 4'd2, '0, 8'h3C);
    waitDone("indirect read");
    doWrite(DIRECT, 4'd2, '0, 8'hF7);
    doRead(INDIRECT, 4'd2, '0, 8'h3C);
    waitDone("indirect upper bits");
    doWrite(INDIRECT, 4'd2, '0, 8'h5A);
    doRead(DIRECT, 4'd7, '0, 8'h5A);
    waitDone("indirect write");

    // Indexed wrap: 14 + 5 lands on 3
    doWrite(INDEXED, 4'd14, 4'd5, 8'h11);
    doRead(DIRECT, 4'd3, '0, 8'h11);
    waitDone("indexed write wrap");
    doRead(INDEXED, 4'd15, 4'd4, 8'h11);
    waitDone("indexed read wrap");

    // Reserved mode: error pulse, no write, no busy
    applyStimulus(1'b1, 1'b1, RSVD, 4'd3, '0, 8'hFF, 1'b0);
    tick(1);
    idleInputs();
    checkOutput("reserved error pulse", {31'd0, error}, 1);
    checkOutput("reserved busy", {31'd0, busy}, 0);
    tick(1);
    checkOutput("reserved error one cycle", {31'd0, error}, 0);
    doRead(DIRECT, 4'd3, '0, 8'h11);
    waitDone("reserved no write");

    // req held through WAIT (and addr changed) is ignored
    pushRead(DIRECT, 8'h11);
    applyStimulus(1'b1, 1'b0, DIRECT, 4'd3, '0, '0, 1'b0);
    tick(1);
    addr = 4'd7;
    tick(2);
    checkOutput("held req ready", {31'd0, dataReady}, 1);
    checkOutput("held req busy drop", {31'd0, busy}, 0);
    idleInputs();
    tick(1);
    checkOutput("held req single read", {31'd0, busy}, 0);
    waitDone("held req");

    // Back-to-back reads, each new one issued in the previous dataReady cycle
    begin
      logic [L-1:0] b2bAddr [4];
      logic [W-1:0] b2bData [4];
      b2bAddr = '{4'd3, 4'd7, 4'd2, 4'd3};
      b2bData = '{8'h11, 8'h5A, 8'hF7, 8'h11};
      for (int i = 0; i < 4; i++) begin
        pushRead(DIRECT, b2bData[i]);
        applyStimulus(1'b1, 1'b0, DIRECT, b2bAddr[i], '0, '0, 1'b0);
        tick(1);
        idleInputs();
        tick(LAT);
        checkOutput("b2b dataReady", {31'd0, dataReady}, 1);
        checkOutput("b2b busy", {31'd0, busy}, 0);
      end
    end
    waitDone("back to back");

    // Reset during WAIT: read aborted, full sweep follows
    applyStimulus(1'b1, 1'b0, DIRECT, 4'd3, '0, '0, 1'b0);
    tick(1);
    idleInputs();
    clr = 1'b1;
    #1;
    checkOutput("midread reset busy", {31'd0, busy}, 1);
    checkOutput("midread reset dataReady", {31'd0, dataReady}, 0);
    checkOutput("midread reset readData", {24'd0, readData}, 0);
    tick(1);
    clr = 1'b0;
    checkSweep("reset sweep", 8'h00);
    doRead(DIRECT, 4'd3, '0, 8'h00);
    waitDone("swept word");

    // clrMem together with req: sweep wins, readData untouched
    doWrite(DIRECT, 4'd5, '0, 8'h42);
    doRead(DIRECT, 4'd5, '0, 8'h42);
    waitDone("pre clrMem read");
    applyStimulus(1'b1, 1'b1, DIRECT, 4'd6, '0, 8'h77, 1'b1);
    tick(1);
    idleInputs();
    checkSweep("clrMem sweep", 8'h42);
    doRead(DIRECT, 4'd5, '0, 8'h00);
    waitDone("clrMem zeroed");
    doRead(DIRECT, 4'd6, '0, 8'h00);
    waitDone("clrMem dropped write");

    tick(2);
    checkOutput("scoreboard drained", sbQueue.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
